// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } slot_t;

endpackage

// File: rtl/fetch_slot_array.sv
// Circular storage for in-flight fetches: tail allocates, fill pointer tracks
// the oldest unfilled slot, head feeds decode.
module fetch_slot_array
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               flush,
    input  logic               allocEn,
    input  logic [XLEN-1:0]    allocPc,
    input  logic               fillEn,
    input  logic [INSTR_W-1:0] fillInstr,
    input  logic               popEn,
    output slot_t              headSlot
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    slot_t           slots [DEPTH];
    logic [PW-1:0]   allocPtr;
    logic [PW-1:0]   fillPtr;
    logic [PW-1:0]   headPtr;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
            allocPtr <= '0;
            fillPtr  <= '0;
            headPtr  <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i].filled <= 1'b0;
            end
            allocPtr <= '0;
            fillPtr  <= '0;
            headPtr  <= '0;
        end else begin
            // Alloc, fill and pop always address distinct slots, so all three may land together.
            if (allocEn) begin
                slots[allocPtr].pc     <= allocPc;
                slots[allocPtr].instr  <= NOP_INSTR;
                slots[allocPtr].filled <= 1'b0;
                allocPtr               <= nextPtr(allocPtr);
            end
            if (fillEn) begin
                slots[fillPtr].instr  <= fillInstr;
                slots[fillPtr].filled <= 1'b1;
                fillPtr               <= nextPtr(fillPtr);
            end
            if (popEn) begin
                slots[headPtr].filled <= 1'b0;
                headPtr               <= nextPtr(headPtr);
            end
        end
    end

    assign headSlot = slots[headPtr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: issues PC requests to instruction memory, matches in-order
// responses to slots, and drops responses that belong to flushed fetches.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = fetch_queue_pkg::XLEN
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic [XLEN-1:0]    pc,
    output logic               stall,
    input  logic               flush,
    output logic               imemReqValid,
    input  logic               imemReqReady,
    output logic [XLEN-1:0]    imemReqAddr,
    input  logic               imemRespValid,
    input  logic [INSTR_W-1:0] imemRespData,
    output logic               decValid,
    input  logic               decReady,
    output logic [XLEN-1:0]    decPc,
    output logic [INSTR_W-1:0] decInstr
);

    localparam int CW       = $clog2(DEPTH + 1) + 1;
    localparam int PKG_XLEN = fetch_queue_pkg::XLEN;

    logic [CW-1:0]       allocCount;
    logic [CW-1:0]       discardCount;
    logic [CW-1:0]       unfilledCount;
    logic [CW-1:0]       outstanding;
    logic                reqFire;
    logic                respFill;
    logic                respDrop;
    logic                popEn;
    logic [PKG_XLEN-1:0] slotPc;
    slot_t               headSlot;

    assign imemReqAddr = pc;

    // Credit check uses registered counts only; a pop frees its slot next cycle.
    always_comb begin
        outstanding  = discardCount + unfilledCount;
        imemReqValid = resetN && !flush && ((allocCount + discardCount) < CW'(DEPTH));
        reqFire      = imemReqValid && imemReqReady;
        if (!resetN) begin
            stall = 1'b1;
        end else if (flush) begin
            stall = 1'b0;
        end else begin
            stall = !reqFire;
        end
        decValid = (allocCount != '0) && headSlot.filled;
        popEn    = decValid && decReady && !flush;
        respDrop = imemRespValid && !flush && (discardCount != '0);
        respFill = imemRespValid && !flush && (discardCount == '0) && (unfilledCount != '0);
        slotPc              = '0;
        slotPc[XLEN-1:0]    = pc;
        decPc    = decValid ? headSlot.pc[XLEN-1:0] : '0;
        decInstr = decValid ? headSlot.instr : NOP_INSTR;
    end

    // On flush every unfilled slot becomes a response to discard; a response
    // arriving in the flush cycle itself retires one of them immediately.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            allocCount    <= '0;
            unfilledCount <= '0;
            discardCount  <= '0;
        end else if (flush) begin
            allocCount    <= '0;
            unfilledCount <= '0;
            discardCount  <= outstanding - CW'(imemRespValid && (outstanding != '0));
        end else begin
            allocCount    <= allocCount + CW'(reqFire) - CW'(popEn);
            unfilledCount <= unfilledCount + CW'(reqFire) - CW'(respFill);
            if (respDrop) begin
                discardCount <= discardCount - CW'(1);
            end
        end
    end

    fetch_slot_array #(
        .DEPTH(DEPTH)
    ) u_slots (
        .clk       (clk),
        .resetN    (resetN),
        .flush     (flush),
        .allocEn   (reqFire),
        .allocPc   (slotPc),
        .fillEn    (respFill),
        .fillInstr (imemRespData),
        .popEn     (popEn),
        .headSlot  (headSlot)
    );

endmodule
